dmem_arbiter: RTL and testbench

Two-requester arbiter for the single external data-memory port (DREQ/DRW/DADDR/DWDATA/DRDATA). It shares that port between the CPU MEM stage (port C) and the custom-IP/DMA master (port I). The CPU has default priority. The IP gets anti-starvation promotion and bounded locked bursts. Read data is steered back to whichever requester issued the read. The block sits between stage_MEM's memory-side outputs and the data RAM, and it drives a stall back to the pipeline hazard logic.

---
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the data-memory port: CPU by default, IP via starvation promotion and locked bursts.
// Latency: grant is combinational (0 cycles); read data returns 1 cycle after the granted DREQ.
// Backpressure: a losing CPU sees CPU_STALL, a losing IP holds IP_REQ until IP_GNT; RSTN low blocks all grants.
module dmem_arbiter #(
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        CPU_REQ,
    input  logic [1:0]  CPU_RW,
    input  logic [31:0] CPU_ADDR,
    input  logic [31:0] CPU_WDATA,
    output logic        CPU_STALL,
    output logic        CPU_RVALID,
    output logic [31:0] CPU_RDATA,
    input  logic        IP_REQ,
    input  logic [1:0]  IP_RW,
    input  logic [31:0] IP_ADDR,
    input  logic [31:0] IP_WDATA,
    input  logic        IP_LOCK,
    output logic        IP_GNT,
    output logic        IP_RVALID,
    output logic [31:0] IP_RDATA,
    output logic        DREQ,
    output logic [1:0]  DRW,
    output logic [31:0] DADDR,
    output logic [31:0] DWDATA,
    input  logic [31:0] DRDATA
);

    typedef enum logic {
        PRIO_CPU  = 1'b0,
        IP_LOCKED = 1'b1
    } state_t;

    localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic [1:0] rd_owner_q;
    logic       starve;
    logic       cpu_gnt, ip_gnt;

    assign starve = (wait_cnt_q == WAIT_MAX);

    // Grant priority; nothing is granted while reset is held.
    always_comb begin
        cpu_gnt = 1'b0;
        ip_gnt  = 1'b0;
        if (RSTN) begin
            if (state_q == IP_LOCKED && IP_REQ) begin
                ip_gnt = 1'b1;
            end else if (CPU_REQ && !starve) begin
                cpu_gnt = 1'b1;
            end else if (IP_REQ) begin
                ip_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        wait_cnt_d = wait_cnt_q;

        if (ip_gnt || !IP_REQ) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q < WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        case (state_q)
            PRIO_CPU: begin
                // A one-beat burst limit means a locked grant never holds the port.
                if (ip_gnt && IP_LOCK && BURST_MAX != 8'd1) begin
                    state_d    = IP_LOCKED;
                    beat_cnt_d = 8'd1;
                end
            end
            IP_LOCKED: begin
                if (!IP_REQ || !IP_LOCK || (beat_cnt_q + 8'd1 == BURST_MAX)) begin
                    state_d    = PRIO_CPU;
                    beat_cnt_d = 8'd0;
                end else begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = PRIO_CPU;
                beat_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q    <= PRIO_CPU;
            wait_cnt_q <= 4'd0;
            beat_cnt_q <= 8'd0;
            rd_owner_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            rd_owner_q <= {ip_gnt & IP_RW[1], cpu_gnt & CPU_RW[1]};
        end
    end

    always_comb begin
        DREQ   = cpu_gnt | ip_gnt;
        DRW    = 2'b00;
        DADDR  = 32'd0;
        DWDATA = 32'd0;
        if (cpu_gnt) begin
            DRW    = CPU_RW;
            DADDR  = CPU_ADDR;
            DWDATA = CPU_WDATA;
        end else if (ip_gnt) begin
            DRW    = IP_RW;
            DADDR  = IP_ADDR;
            DWDATA = IP_WDATA;
        end
    end

    assign CPU_STALL  = CPU_REQ & ~cpu_gnt;
    assign IP_GNT     = ip_gnt;
    // Gating with RSTN drops a read that was in flight when reset hit.
    assign CPU_RVALID = RSTN & rd_owner_q[0];
    assign IP_RVALID  = RSTN & rd_owner_q[1];
    assign CPU_RDATA  = CPU_RVALID ? DRDATA : 32'd0;
    assign IP_RDATA   = IP_RVALID ? DRDATA : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table for single-cycle behaviour plus multi-cycle sequences.
module tb_dmem_arbiter;

    localparam int MW = 4;
    localparam int MB = 8;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        CPU_REQ, IP_REQ, IP_LOCK;
    logic [1:0]  CPU_RW, IP_RW;
    logic [31:0] CPU_ADDR, CPU_WDATA, IP_ADDR, IP_WDATA, DRDATA;
    logic        CPU_STALL, CPU_RVALID, IP_GNT, IP_RVALID, DREQ;
    logic [31:0] CPU_RDATA, IP_RDATA, DADDR, DWDATA;
    logic [1:0]  DRW;

    int checks = 0;
    int failures = 0;

    dmem_arbiter #(.MAX_WAIT(MW), .MAX_BURST(MB)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .CPU_REQ(CPU_REQ), .CPU_RW(CPU_RW), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_STALL(CPU_STALL), .CPU_RVALID(CPU_RVALID), .CPU_RDATA(CPU_RDATA),
        .IP_REQ(IP_REQ), .IP_RW(IP_RW), .IP_ADDR(IP_ADDR), .IP_WDATA(IP_WDATA),
        .IP_LOCK(IP_LOCK), .IP_GNT(IP_GNT), .IP_RVALID(IP_RVALID), .IP_RDATA(IP_RDATA),
        .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA), .DRDATA(DRDATA)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rstn;
        logic        cr;
        logic [1:0]  crw;
        logic [31:0] ca, cwd;
        logic        ir;
        logic [1:0]  irw;
        logic [31:0] ia, iwd;
        logic        il;
        logic [31:0] drd;
        logic        e_stall, e_gnt, e_dreq;
        logic [1:0]  e_drw;
        logic [31:0] e_daddr, e_dwd;
        logic        e_cv;
        logic [31:0] e_cd;
        logic        e_iv;
        logic [31:0] e_id;
    } vec_t;

    function automatic vec_t mk(
        input logic rstn, input logic cr, input logic [1:0] crw, input logic [31:0] ca, input logic [31:0] cwd,
        input logic ir, input logic [1:0] irw, input logic [31:0] ia, input logic [31:0] iwd, input logic il,
        input logic [31:0] drd,
        input logic s, input logic g, input logic dq, input logic [1:0] drw, input logic [31:0] da,
        input logic [31:0] dw, input logic cv, input logic [31:0] cd, input logic iv, input logic [31:0] id);
        vec_t v;
        v.rstn = rstn; v.cr = cr; v.crw = crw; v.ca = ca; v.cwd = cwd;
        v.ir = ir; v.irw = irw; v.ia = ia; v.iwd = iwd; v.il = il; v.drd = drd;
        v.e_stall = s; v.e_gnt = g; v.e_dreq = dq; v.e_drw = drw; v.e_daddr = da;
        v.e_dwd = dw; v.e_cv = cv; v.e_cd = cd; v.e_iv = iv; v.e_id = id;
        return v;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic rstn, input logic cr, input logic [1:0] crw, input logic [31:0] ca,
                         input logic [31:0] cwd, input logic ir, input logic [1:0] irw, input logic [31:0] ia,
                         input logic [31:0] iwd, input logic il, input logic [31:0] drd);
        @(negedge CLK);
        RSTN = rstn; CPU_REQ = cr; CPU_RW = crw; CPU_ADDR = ca; CPU_WDATA = cwd;
        IP_REQ = ir; IP_RW = irw; IP_ADDR = ia; IP_WDATA = iwd; IP_LOCK = il; DRDATA = drd;
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    vec_t vt[8];

    initial begin
        RSTN = 1'b0; CPU_REQ = 1'b0; CPU_RW = 2'b00; CPU_ADDR = 32'd0; CPU_WDATA = 32'd0;
        IP_REQ = 1'b0; IP_RW = 2'b00; IP_ADDR = 32'd0; IP_WDATA = 32'd0; IP_LOCK = 1'b0; DRDATA = 32'd0;

        // reset: only CPU_STALL follows CPU_REQ
        vt[0] = mk(0, 1, 2'b10, 32'h100, 32'h0, 1, 2'b10, 32'h300, 32'h0, 1, 32'h5555_5555,
                   1, 0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        vt[1] = mk(0, 0, 2'b00, 32'h0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h6666_6666,
                   0, 0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        // CPU-only read then write
        vt[2] = mk(1, 1, 2'b10, 32'h100, 32'h0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0,
                   0, 0, 1, 2'b10, 32'h100, 32'h0, 0, 32'h0, 0, 32'h0);
        vt[3] = mk(1, 1, 2'b01, 32'h104, 32'hDEAD_BEEF, 0, 2'b00, 32'h0, 32'h0, 0, 32'h1111_2222,
                   0, 0, 1, 2'b01, 32'h104, 32'hDEAD_BEEF, 1, 32'h1111_2222, 0, 32'h0);
        vt[4] = mk(1, 0, 2'b00, 32'h0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h3333_4444,
                   0, 0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        // read steering: CPU read, IP read, then both returns
        vt[5] = mk(1, 1, 2'b10, 32'h200, 32'h0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0,
                   0, 0, 1, 2'b10, 32'h200, 32'h0, 0, 32'h0, 0, 32'h0);
        vt[6] = mk(1, 0, 2'b00, 32'h0, 32'h0, 1, 2'b11, 32'h300, 32'h77, 0, 32'hAAAA_0001,
                   0, 1, 1, 2'b11, 32'h300, 32'h77, 1, 32'hAAAA_0001, 0, 32'h0);
        vt[7] = mk(1, 0, 2'b00, 32'h0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 0, 32'hBBBB_0002,
                   0, 0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 1, 32'hBBBB_0002);

        for (int i = 0; i < 8; i++) begin
            drive(vt[i].rstn, vt[i].cr, vt[i].crw, vt[i].ca, vt[i].cwd, vt[i].ir, vt[i].irw,
                  vt[i].ia, vt[i].iwd, vt[i].il, vt[i].drd);
            chk($sformatf("vec%0d", i),
                160'({CPU_STALL, IP_GNT, DREQ, DRW, DADDR, DWDATA, CPU_RVALID, CPU_RDATA, IP_RVALID, IP_RDATA}),
                160'({vt[i].e_stall, vt[i].e_gnt, vt[i].e_dreq, vt[i].e_drw, vt[i].e_daddr, vt[i].e_dwd,
                      vt[i].e_cv, vt[i].e_cd, vt[i].e_iv, vt[i].e_id}));
        end

        // contention: IP wins every MW+1 cycles
        for (int c = 1; c <= 15; c++) begin
            logic g;
            g = (c % (MW + 1)) == 0;
            drive(1, 1, 2'b01, 32'h400, 32'h1, 1, 2'b01, 32'h800, 32'h2, 0, 32'h0);
            chk($sformatf("contend%0d", c), 160'({IP_GNT, CPU_STALL, DREQ, DADDR}),
                160'({g, g, 1'b1, g ? 32'h800 : 32'h400}));
        end
        idle();

        // locked burst of 12 IP reads against a continuous CPU writer
        begin
            logic prev_g = 1'b0;
            for (int c = 1; c <= 21; c++) begin
                logic g;
                logic [31:0] drd;
                drd = 32'hD000_0000 | 32'(c);
                g = (c >= 5 && c <= 12) || (c >= 17 && c <= 20);
                drive(1, 1, 2'b01, 32'h500, 32'h9, c <= 20, 2'b10, 32'h900 + 32'(c), 32'h0, 1, drd);
                chk($sformatf("burst%0d", c), 160'({IP_GNT, CPU_STALL, DREQ, IP_RVALID, IP_RDATA, CPU_RVALID}),
                    160'({g, g, 1'b1, prev_g, prev_g ? drd : 32'h0, 1'b0}));
                prev_g = g;
            end
        end
        idle();

        // early unlock: lock dropped on beat 3
        for (int c = 1; c <= 9; c++) begin
            logic g;
            g = (c >= 5 && c <= 7);
            drive(1, 1, 2'b01, 32'h600, 32'h0, 1, 2'b01, 32'hA00, 32'h0, c < 7, 32'h0);
            chk($sformatf("unlock%0d", c), 160'({IP_GNT, CPU_STALL}), 160'({g, g}));
        end
        idle();

        // reset during beat 4 of a locked read burst
        for (int c = 1; c <= 3; c++) begin
            drive(1, 0, 2'b00, 32'h0, 32'h0, 1, 2'b10, 32'hB00, 32'h0, 1, 32'hCAFE_0000);
            chk($sformatf("rstburst%0d", c), 160'({IP_GNT, DREQ}), 160'({1'b1, 1'b1}));
        end
        drive(0, 0, 2'b00, 32'h0, 32'h0, 1, 2'b10, 32'hB00, 32'h0, 1, 32'hCAFE_0004);
        chk("rst_beat4", 160'({IP_GNT, DREQ, IP_RVALID, IP_RDATA, CPU_STALL}), 160'(0));
        drive(1, 0, 2'b00, 32'h0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 0, 32'hCAFE_0005);
        chk("rst_after", 160'({IP_RVALID, CPU_RVALID, DREQ, IP_RDATA}), 160'(0));
        drive(1, 1, 2'b10, 32'h700, 32'h0, 1, 2'b10, 32'hB00, 32'h0, 1, 32'h0);
        chk("rst_cpu_wins", 160'({IP_GNT, CPU_STALL, DREQ, DADDR}), 160'({1'b0, 1'b0, 1'b1, 32'h700}));
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
